// File: rtl/aes_key_expand.sv
// AES-128 round-key generator: presents keys 0..10 on eleven consecutive cycles
// after an accepted start, then pulses done for one cycle.
module aes_key_expand (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic [127:0] round_key,
    output logic [3:0]   round_num,
    output logic         key_valid,
    output logic         busy,
    output logic         done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'd10;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    state_t       r_state;
    state_t       w_state_next;
    logic [127:0] r_round_key;
    logic [127:0] w_round_key_next;
    logic [3:0]   r_round_num;
    logic [3:0]   w_round_num_next;
    logic [7:0]   r_rcon;
    logic [7:0]   w_rcon_next;
    logic         r_key_valid;
    logic         w_key_valid_next;
    logic         r_busy;
    logic         w_busy_next;
    logic         r_done;
    logic         w_done_next;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [31:0]  w_t;
    logic [31:0]  w_w4, w_w5, w_w6, w_w7;
    logic [127:0] w_key_step;
    logic [7:0]   w_rcon_x2;

    assign w_w0 = r_round_key[127:96];
    assign w_w1 = r_round_key[95:64];
    assign w_w2 = r_round_key[63:32];
    assign w_w3 = r_round_key[31:0];

    // RotWord: bytes {b0,b1,b2,b3} become {b1,b2,b3,b0}
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_subword
            assign w_sub[gi*8 +: 8] = SBOX[w_rot[gi*8 +: 8]];
        end
    endgenerate

    assign w_t        = w_sub ^ {r_rcon, 24'h000000};
    assign w_w4       = w_w0 ^ w_t;
    assign w_w5       = w_w4 ^ w_w1;
    assign w_w6       = w_w5 ^ w_w2;
    assign w_w7       = w_w6 ^ w_w3;
    assign w_key_step = {w_w4, w_w5, w_w6, w_w7};
    assign w_rcon_x2  = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_round_key <= '0;
            r_round_num <= '0;
            r_rcon      <= 8'h01;
            r_key_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_round_key <= w_round_key_next;
            r_round_num <= w_round_num_next;
            r_rcon      <= w_rcon_next;
            r_key_valid <= w_key_valid_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_round_key_next = r_round_key;
        w_round_num_next = r_round_num;
        w_rcon_next      = r_rcon;
        w_key_valid_next = r_key_valid;
        w_busy_next      = r_busy;
        w_done_next      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next     = S_RUN;
                    w_round_key_next = key_in;
                    w_round_num_next = 4'd0;
                    w_rcon_next      = 8'h01;
                    w_key_valid_next = 1'b1;
                    w_busy_next      = 1'b1;
                end
            end
            S_RUN: begin
                // start is deliberately not looked at here
                if (r_round_num != LAST_ROUND) begin
                    w_round_key_next = w_key_step;
                    w_round_num_next = r_round_num + 4'd1;
                    w_rcon_next      = w_rcon_x2;
                end else begin
                    w_state_next     = S_IDLE;
                    w_key_valid_next = 1'b0;
                    w_busy_next      = 1'b0;
                    w_done_next      = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign round_key = r_round_key;
    assign round_num = r_round_num;
    assign key_valid = r_key_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand against a FIPS-197 key-schedule model
// whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_key_expand;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic [127:0] round_key;
    logic [3:0]   round_num;
    logic         key_valid;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    logic [127:0] exp_keys [11];
    logic [127:0] got_keys [11];

    localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K0_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] K0_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    aes_key_expand dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .round_key (round_key),
        .round_num (round_num),
        .key_valid (key_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] v);
        logic [7:0] inv = 8'h00;
        if (v != 8'h00) begin
            for (int y = 1; y < 256; y++)
                if (gmul(v, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
    endfunction

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_ref(tmp[31:24]), sbox_ref(tmp[23:16]),
                       sbox_ref(tmp[15:8]),  sbox_ref(tmp[7:0])} ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic kick(input logic [127:0] key);
        start  = 1'b1;
        key_in = key;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_key"},   round_key, 128'h0);
        chk({tag, "_rnum"},  128'(round_num), 128'h0);
        chk({tag, "_valid"}, 128'(key_valid), 128'h0);
        chk({tag, "_busy"},  128'(busy), 128'h0);
        chk({tag, "_done"},  128'(done), 128'h0);
    endtask

    // Caller has raised start with key before the coming edge; we follow the 11 keys.
    // disturb: round at which a competing start is pulsed; abort: round at which rst hits.
    task automatic run(input logic [127:0] key, input int disturb, input int abort,
                       input bit chain, input logic [127:0] chain_key);
        model_expand(key);
        for (int r = 0; r <= 10; r++) begin
            @(negedge clk);
            got_keys[r] = round_key;
            chk($sformatf("key_r%0d", r),   round_key, exp_keys[r]);
            chk($sformatf("rnum_r%0d", r),  128'(round_num), 128'(r));
            chk($sformatf("valid_r%0d", r), 128'(key_valid), 128'h1);
            chk($sformatf("busy_r%0d", r),  128'(busy), 128'h1);
            chk($sformatf("done_r%0d", r),  128'(done), 128'h0);
            start  = 1'b0;
            key_in = {$urandom, $urandom, $urandom, $urandom};
            if (r == disturb) start = 1'b1;
            if (r == abort) begin
                start = 1'b1;
                #2 rst = 1'b1;
                #1 chk_idle_zero("async_rst");
                @(negedge clk);
                chk_idle_zero("rst_hold");
                rst   = 1'b0;
                start = 1'b0;
                @(negedge clk);
                chk_idle_zero("post_rst");
                $display("expand key=%h aborted at round %0d", key, r);
                return;
            end
        end
        @(negedge clk);
        chk("done_pulse", 128'(done), 128'h1);
        chk("done_valid", 128'(key_valid), 128'h0);
        chk("done_busy",  128'(busy), 128'h0);
        chk("done_rnum",  128'(round_num), 128'd10);
        chk("done_key",   round_key, exp_keys[10]);
        start = 1'b0;
        if (chain) begin
            kick(chain_key);
        end else begin
            @(negedge clk);
            chk("after_done", 128'(done), 128'h0);
            chk("after_valid", 128'(key_valid), 128'h0);
            chk("after_rnum", 128'(round_num), 128'd10);
        end
        $display("expand key=%h disturb=%0d chain=%0d", key, disturb, chain);
    endtask

    initial begin
        logic [127:0] rk;
        rst    = 1'b1;
        start  = 1'b0;
        key_in = '0;
        @(negedge clk);
        chk_idle_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_idle_zero("idle");

        kick(K1);
        run(K1, -1, -1, 1'b0, '0);
        chk("k1_r0", got_keys[0], K1);
        chk("k1_r1", got_keys[1], K1_R1);
        chk("k1_r10", got_keys[10], K1_R10);

        kick(128'h0);
        run(128'h0, -1, -1, 1'b0, '0);
        chk("k0_r1", got_keys[1], K0_R1);
        chk("k0_r10", got_keys[10], K0_R10);

        kick(K1);
        run(K1, 4, -1, 1'b0, '0);
        chk("dist_r10", got_keys[10], K1_R10);

        kick(K1);
        run(K1, -1, 5, 1'b0, '0);
        kick(K1);
        run(K1, -1, -1, 1'b0, '0);
        chk("restart_r1", got_keys[1], K1_R1);

        kick(K1);
        run(K1, -1, -1, 1'b1, 128'h0);
        run(128'h0, -1, -1, 1'b0, '0);
        chk("chain_r10", got_keys[10], K0_R10);

        for (int n = 0; n < 6; n++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            kick(rk);
            run(rk, int'($urandom_range(0, 10)), -1, n[0], {$urandom, $urandom, $urandom, $urandom});
            if (n[0]) run(key_in, -1, -1, 1'b0, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
